// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-requester round-robin DRAM arbiter with in-order read return routing
module dram_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 18,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  srstn,

  input  logic                  m0_en_rd,
  input  logic [ADDR_WIDTH-1:0] m0_addr_rd,
  output logic                  m0_gnt_rd,
  output logic                  m0_valid,
  output logic [DATA_WIDTH-1:0] m0_data_rd,
  input  logic                  m0_en_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr_wr,
  input  logic [DATA_WIDTH-1:0] m0_data_wr,
  output logic                  m0_gnt_wr,

  input  logic                  m1_en_rd,
  input  logic [ADDR_WIDTH-1:0] m1_addr_rd,
  output logic                  m1_gnt_rd,
  output logic                  m1_valid,
  output logic [DATA_WIDTH-1:0] m1_data_rd,
  input  logic                  m1_en_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr_wr,
  input  logic [DATA_WIDTH-1:0] m1_data_wr,
  output logic                  m1_gnt_wr,

  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] dram_data_rd,
  output logic                  dram_en_wr,
  output logic [ADDR_WIDTH-1:0] dram_addr_wr,
  output logic [DATA_WIDTH-1:0] dram_data_wr,

  output logic                  err_orphan
);

  localparam int PTR_W = (MAX_OUTSTANDING > 2) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Tag FIFO: one bit per in-flight read naming the requester that issued it.
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  // Round-robin pointers: 0 names m0, 1 names m1.
  logic rr_rd;
  logic rr_wr;

  logic                  rd_room;
  logic                  rd_req0;
  logic                  rd_req1;
  logic                  rd_both;
  logic                  rd_gnt;
  logic                  rd_win;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;

  logic                  wr_req0;
  logic                  wr_req1;
  logic                  wr_both;
  logic                  wr_gnt;
  logic                  wr_win;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;

  logic empty;
  logic head;
  logic push;
  logic pop;

  // Read arbitration: the full check looks only at the registered count, so a pop in
  // the same cycle never opens a slot early.
  always_comb begin
    rd_room     = (count < CNT_W'(MAX_OUTSTANDING));
    rd_req0     = srstn & m0_en_rd & rd_room;
    rd_req1     = srstn & m1_en_rd & rd_room;
    rd_both     = rd_req0 & rd_req1;
    rd_gnt      = rd_req0 | rd_req1;
    rd_win      = rd_both ? rr_rd : rd_req1;
    rd_addr_sel = rd_win ? m1_addr_rd : m0_addr_rd;
  end

  // Write arbitration: same rules as reads but never throttled by the tag FIFO.
  always_comb begin
    wr_req0     = srstn & m0_en_wr;
    wr_req1     = srstn & m1_en_wr;
    wr_both     = wr_req0 & wr_req1;
    wr_gnt      = wr_req0 | wr_req1;
    wr_win      = wr_both ? rr_wr : wr_req1;
    wr_addr_sel = wr_win ? m1_addr_wr : m0_addr_wr;
    wr_data_sel = wr_win ? m1_data_wr : m0_data_wr;
  end

  assign m0_gnt_rd = rd_gnt & ~rd_win;
  assign m1_gnt_rd = rd_gnt &  rd_win;
  assign m0_gnt_wr = wr_gnt & ~wr_win;
  assign m1_gnt_wr = wr_gnt &  wr_win;

  // Return routing: the FIFO head says whose read the DRAM is answering right now.
  always_comb begin
    empty = (count == '0);
    head  = tag_mem[rd_ptr];
    push  = rd_gnt;
    pop   = dram_valid & ~empty;
  end

  assign m0_valid   = dram_valid & ~empty & ~head;
  assign m1_valid   = dram_valid & ~empty &  head;
  assign m0_data_rd = dram_data_rd;
  assign m1_data_rd = dram_data_rd;

  // Pointers only move on contention; a lone winner leaves the pointer where it was.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      rr_rd <= 1'b0;
      rr_wr <= 1'b0;
    end else begin
      if (rd_both) rr_rd <= ~rr_rd;
      if (wr_both) rr_wr <= ~wr_win;
    end
  end

  // Read issue register: enable pulses one cycle after a grant, address holds otherwise.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      dram_en_rd   <= 1'b0;
      dram_addr_rd <= '0;
    end else begin
      dram_en_rd <= rd_gnt;
      if (rd_gnt) dram_addr_rd <= rd_addr_sel;
    end
  end

  // Write issue register: enable pulses one cycle after a grant, addr/data hold otherwise.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      dram_en_wr   <= 1'b0;
      dram_addr_wr <= '0;
      dram_data_wr <= '0;
    end else begin
      dram_en_wr <= wr_gnt;
      if (wr_gnt) begin
        dram_addr_wr <= wr_addr_sel;
        dram_data_wr <= wr_data_sel;
      end
    end
  end

  // Tag FIFO storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= rd_win;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a DRAM return that no outstanding read accounts for.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      err_orphan <= 1'b0;
    end else if (dram_valid && empty) begin
      err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - randomized self-checking bench for dram_arbiter
module tb_dram_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 18;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  logic          r_en   [2];
  logic [AW-1:0] r_addr [2];
  logic          w_en   [2];
  logic [AW-1:0] w_addr [2];
  logic [DW-1:0] w_data [2];
  logic          dv;
  logic [DW-1:0] dd;

  logic          m0_gnt_rd, m1_gnt_rd, m0_gnt_wr, m1_gnt_wr;
  logic          m0_valid, m1_valid;
  logic [DW-1:0] m0_data_rd, m1_data_rd;
  logic          dram_en_rd, dram_en_wr, err_orphan;
  logic [AW-1:0] dram_addr_rd, dram_addr_wr;
  logic [DW-1:0] dram_data_wr;

  dram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .srstn(srstn),
    .m0_en_rd(r_en[0]), .m0_addr_rd(r_addr[0]), .m0_gnt_rd(m0_gnt_rd),
    .m0_valid(m0_valid), .m0_data_rd(m0_data_rd),
    .m0_en_wr(w_en[0]), .m0_addr_wr(w_addr[0]), .m0_data_wr(w_data[0]), .m0_gnt_wr(m0_gnt_wr),
    .m1_en_rd(r_en[1]), .m1_addr_rd(r_addr[1]), .m1_gnt_rd(m1_gnt_rd),
    .m1_valid(m1_valid), .m1_data_rd(m1_data_rd),
    .m1_en_wr(w_en[1]), .m1_addr_wr(w_addr[1]), .m1_data_wr(w_data[1]), .m1_gnt_wr(m1_gnt_wr),
    .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
    .dram_valid(dv), .dram_data_rd(dd),
    .dram_en_wr(dram_en_wr), .dram_addr_wr(dram_addr_wr), .dram_data_wr(dram_data_wr),
    .err_orphan(err_orphan)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int            tagq[$];
  int            rr_rd, rr_wr;
  logic          x_en_rd, x_en_wr, x_orphan;
  logic [AW-1:0] x_addr_rd, x_addr_wr;
  logic [DW-1:0] x_data_wr;
  int            pending;
  int            g_rd, g_wr;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic a, input logic b, input int rr);
    if (a && b) return rr;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    tagq.delete();
    rr_rd = 0; rr_wr = 0;
    x_en_rd = 1'b0; x_en_wr = 1'b0; x_orphan = 1'b0;
    x_addr_rd = '0; x_addr_wr = '0; x_data_wr = '0;
    pending = 0; g_rd = -1; g_wr = -1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      r_en[i] = 1'b0; w_en[i] = 1'b0;
    end
    dv = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; checks, advances the model, waits.
  task automatic step();
    int gr, gw;
    logic [1:0] egr, egw, ev;
    logic room;
    #1;
    room = (tagq.size() < MAXO);
    gr = pick(r_en[0] && room, r_en[1] && room, rr_rd);
    gw = pick(w_en[0], w_en[1], rr_wr);
    egr = (gr < 0) ? 2'b00 : ((gr == 0) ? 2'b01 : 2'b10);
    egw = (gw < 0) ? 2'b00 : ((gw == 0) ? 2'b01 : 2'b10);
    ev = 2'b00;
    if (dv && tagq.size() > 0) ev = (tagq[0] == 0) ? 2'b01 : 2'b10;

    check_eq("gnt_rd", {m1_gnt_rd, m0_gnt_rd}, egr);
    check_eq("gnt_wr", {m1_gnt_wr, m0_gnt_wr}, egw);
    check_eq("valid", {m1_valid, m0_valid}, ev);
    if (dv) begin
      check_eq("m0_data_rd", m0_data_rd, dd);
      check_eq("m1_data_rd", m1_data_rd, dd);
    end
    check_eq("dram_en_rd", dram_en_rd, x_en_rd);
    check_eq("dram_addr_rd", dram_addr_rd, x_addr_rd);
    check_eq("dram_en_wr", dram_en_wr, x_en_wr);
    check_eq("dram_addr_wr", dram_addr_wr, x_addr_wr);
    check_eq("dram_data_wr", dram_data_wr, x_data_wr);
    check_eq("err_orphan", err_orphan, x_orphan);

    if (r_en[0] && r_en[1] && gr >= 0) rr_rd = 1 - rr_rd;
    if (w_en[0] && w_en[1]) rr_wr = 1 - rr_wr;
    if (x_en_rd) pending++;
    if (dv) begin
      if (tagq.size() == 0) x_orphan = 1'b1;
      else void'(tagq.pop_front());
      if (pending > 0) pending--;
    end
    if (gr >= 0) tagq.push_back(gr);
    x_en_rd = (gr >= 0);
    if (gr >= 0) x_addr_rd = r_addr[gr];
    x_en_wr = (gw >= 0);
    if (gw >= 0) begin
      x_addr_wr = w_addr[gw];
      x_data_wr = w_data[gw];
    end
    g_rd = gr; g_wr = gw;
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n);
    g_rd = -1; g_wr = -1;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (r_en[i] && g_rd == i) r_en[i] = 1'b0;
        else if (r_en[i] && $urandom_range(15) == 0) r_en[i] = 1'b0;
        if (!r_en[i] && $urandom_range(2) == 0) begin
          r_en[i] = 1'b1; r_addr[i] = AW'($urandom);
        end
        if (w_en[i] && g_wr == i) w_en[i] = 1'b0;
        else if (w_en[i] && $urandom_range(15) == 0) w_en[i] = 1'b0;
        if (!w_en[i] && $urandom_range(2) == 0) begin
          w_en[i] = 1'b1; w_addr[i] = AW'($urandom); w_data[i] = $urandom;
        end
      end
      dv = (pending > 0) && ($urandom_range(2) == 0);
      dd = $urandom;
      step();
    end
    clear_inputs();
  endtask

  task automatic drain();
    clear_inputs();
    for (int k = 0; k < 20 && tagq.size() > 0; k++) begin
      dv = 1'b1; dd = $urandom;
      step();
    end
    dv = 1'b0;
    check_eq("drained", tagq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = '0; w_addr[i] = '0; w_data[i] = '0;
    end
    dd = '0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    srstn = 1'b1;

    // single requester read and return
    r_en[0] = 1'b1; r_addr[0] = 18'h00010;
    step();
    r_en[0] = 1'b0;
    step();
    dv = 1'b1; dd = 32'h1234_5678;
    step();
    dv = 1'b0;
    step();

    // contention, then backpressure at full occupancy
    r_en[0] = 1'b1; r_addr[0] = 18'h00100;
    r_en[1] = 1'b1; r_addr[1] = 18'h00200;
    repeat (5) step();
    dv = 1'b1; dd = 32'h0000_00F0;
    step();
    dv = 1'b0;
    step();
    drain();
    step();

    // routing m1, m0, m1 then three returns
    r_en[1] = 1'b1; r_addr[1] = 18'h00001; step(); r_en[1] = 1'b0;
    r_en[0] = 1'b1; r_addr[0] = 18'h00002; step(); r_en[0] = 1'b0;
    r_en[1] = 1'b1; r_addr[1] = 18'h00003; step(); r_en[1] = 1'b0;
    step();
    dv = 1'b1;
    dd = 32'hA; step();
    dd = 32'hB; step();
    dd = 32'hC; step();
    dv = 1'b0;
    step();

    // write concurrent with a read
    w_en[0] = 1'b1; w_addr[0] = 18'h3FFFF; w_data[0] = 32'hDEADBEEF;
    r_en[1] = 1'b1; r_addr[1] = 18'h00777;
    step();
    clear_inputs();
    step();
    drain();

    // randomized traffic
    rand_cycles(3000);
    drain();
    step();

    // orphan return
    dv = 1'b1; dd = 32'h5555_AAAA;
    step();
    dv = 1'b0;
    repeat (3) step();

    // reset with two reads outstanding
    r_en[0] = 1'b1; r_addr[0] = 18'h00AAA; step(); r_en[0] = 1'b0;
    r_en[1] = 1'b1; r_addr[1] = 18'h00BBB; step(); r_en[1] = 1'b0;
    clear_inputs();
    #2;
    srstn = 1'b0;
    #1;
    check_eq("rst_en_rd", dram_en_rd, 1'b0);
    check_eq("rst_addr_rd", dram_addr_rd, '0);
    check_eq("rst_en_wr", dram_en_wr, 1'b0);
    check_eq("rst_addr_wr", dram_addr_wr, '0);
    check_eq("rst_data_wr", dram_data_wr, '0);
    check_eq("rst_err_orphan", err_orphan, 1'b0);
    check_eq("rst_gnt", {m1_gnt_rd, m0_gnt_rd, m1_gnt_wr, m0_gnt_wr}, 4'b0000);
    model_reset();
    @(negedge clk);
    srstn = 1'b1;
    // late return from before reset is an orphan
    dv = 1'b1; dd = 32'h0BAD_0BAD;
    step();
    dv = 1'b0;
    repeat (2) step();
    // full depth available again after reset
    r_en[0] = 1'b1; r_addr[0] = 18'h00123;
    repeat (5) step();
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM model between two layer engines (m0 = conv_layer, m1 = next layer engine).
- Read and write channels are arbitrated independently, each with its own round-robin pointer.
- Read returns are routed back to the issuing requester through an in-order tag FIFO.
- Sits between the engines and the dram instance, exposing the DRAM's existing en/addr/data/valid signalling on both sides.

Parameters:
DATA_WIDTH, 32, DRAM word width
ADDR_WIDTH, 18, DRAM address width
MAX_OUTSTANDING, 4, read tag FIFO depth (maximum in-flight reads); power of two, at least 2

Ports:
clk  in  1  clock, all logic on rising edge
srstn  in  1  asynchronous active-low reset
m0_en_rd  in  1  m0 read request
m0_addr_rd  in  ADDR_WIDTH  m0 read address
m0_gnt_rd  out  1  m0 read granted this cycle
m0_valid  out  1  read data valid for m0
m0_data_rd  out  DATA_WIDTH  read data to m0
m0_en_wr  in  1  m0 write request
m0_addr_wr  in  ADDR_WIDTH  m0 write address
m0_data_wr  in  DATA_WIDTH  m0 write data
m0_gnt_wr  out  1  m0 write granted this cycle
m1_*  (same set as m0_*, for requester 1)
dram_en_rd  out  1  read enable to DRAM (registered)
dram_addr_rd  out  ADDR_WIDTH  read address to DRAM (registered)
dram_valid  in  1  DRAM read data valid; DRAM returns reads in issue order
dram_data_rd  in  DATA_WIDTH  DRAM read data
dram_en_wr  out  1  write enable to DRAM (registered)
dram_addr_wr  out  ADDR_WIDTH  write address to DRAM (registered)
dram_data_wr  out  DATA_WIDTH  write data to DRAM (registered)
err_orphan  out  1  sticky: dram_valid seen with no outstanding read

Behaviour:
- Reset values: all dram_* outputs 0, err_orphan 0, tag FIFO empty (count 0), both RR pointers = m0. gnt_* outputs are combinational and are 0 when there is no request.
- Request handshake: requester holds en and addr (and data for writes) until it sees gnt high in the same cycle. gnt is combinational from requests, RR pointer and FIFO count. A request deasserted before grant is dropped without side effects.
- Read arbitration: a read grant is possible only when count < MAX_OUTSTANDING.
  - Only one requesting: it wins.
  - Both requesting: the requester named by the RR pointer wins, and the pointer then moves to the other requester.
  - Pointer is unchanged when there is no grant or when a single requester wins while the pointer already names it; otherwise the pointer moves to the loser.
- Write arbitration: identical rules with its own pointer. Writes are not limited by the FIFO.
- Issue latency: on a granted read in cycle N, dram_en_rd=1 and dram_addr_rd=granted address in cycle N+1. Writes are the same with dram_en_wr/addr/data. The en outputs are 0 in any cycle following a cycle with no grant; addr/data hold their last value.
- Tag FIFO: on a read grant, push the winner ID (0/1). On dram_valid, pop the head.
  - Push and pop in the same cycle: count unchanged.
  - Full-state grant check uses the registered count only; a same-cycle pop does not unblock a grant.
- Return routing (combinational, zero latency):
  - m0_valid = dram_valid & !empty & head==0; m1_valid = dram_valid & !empty & head==1.
  - m0_data_rd = m1_data_rd = dram_data_rd.
- Orphan: dram_valid with FIFO empty sets err_orphan (held until reset). No valid is routed and count stays 0.
- Ordering: no reordering inside a channel. A read and a write to the same address forwarded in the same cycle reach the DRAM in the same cycle; the resulting order is the DRAM's.
- Reset mid-operation: FIFO, pointers and outputs clear immediately (asynchronously). In-flight returns arriving after reset are treated as orphans. The integration requires the DRAM to be reset together with the arbiter.

Test Plan:
- Single requester: m0 reads addr 0x00010 for 1 cycle -> m0_gnt_rd=1 same cycle; dram_en_rd=1, dram_addr_rd=0x00010 next cycle; returned word appears on m0 with m0_valid=1, m1_valid=0.
- Contention: m0 and m1 both hold reads for 4 cycles (addr 0x100 / 0x200), DRAM stalled -> grants alternate m0,m1,m0,m1; dram_addr_rd sequence 0x100,0x200,0x100,0x200.
- Backpressure: 4 granted reads, DRAM returns none -> 5th request gets gnt=0. When dram_valid pulses, the next cycle grants it. A grant concurrent with the pop in the full cycle must not happen.
- Routing: issue m1, m0, m1, then return 0xA,0xB,0xC -> m1 gets 0xA, m0 gets 0xB, m1 gets 0xC.
- Writes concurrent with reads: m0 writes 0x3FFFF←0xDEADBEEF while m1 reads -> both granted same cycle; dram_en_wr and dram_en_rd both high next cycle with correct addr/data.
- Orphan and reset: dram_valid with empty FIFO -> err_orphan=1 stays high. Assert srstn low mid-burst with 2 reads outstanding -> all outputs 0 immediately and count 0; err_orphan clears.
